framebuffer_swap_ctrl: RTL and testbench

- Double-buffered framebuffer controller directly downstream of the voxel renderer.
- Accepts the renderer's pixel writes (coords, palette colour, write enable) into the back bank.
- Serves VGA reads from the front bank and swaps banks at vertical blank once the renderer signals frame completion.
- Clears the back bank to the sky colour before each frame, then releases the renderer with render_ack.

---
 rtl/framebuffer_swap_ctrl_pkg.sv | 34 +++
 rtl/framebuffer_swap_ctrl_if.sv | 41 ++++
 rtl/framebuffer_swap_ctrl_addr_gen.sv | 10 +
 rtl/framebuffer_swap_ctrl.sv | 155 +++++++++++++++
 tb/tb_framebuffer_swap_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/framebuffer_swap_ctrl_pkg.sv
// Shared constants, types and the y*320+x shift-add used by both address paths.
package framebuffer_swap_ctrl_pkg;

  localparam int unsigned COLOR_W   = 8;
  localparam int unsigned FB_W      = 320;
  localparam int unsigned FB_H      = 240;
  localparam int unsigned VIS_W     = 640;
  localparam int unsigned VIS_H     = 480;
  localparam int unsigned FB_PIXELS = FB_W * FB_H;
  localparam int unsigned LIN_W     = 17;
  localparam int unsigned ADDR_W    = LIN_W + 1;
  localparam int unsigned PX_X_W    = 9;
  localparam int unsigned PX_Y_W    = 8;
  localparam int unsigned DRAW_W    = 10;

  typedef logic [LIN_W-1:0] fb_addr_t;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_ACK,
    ST_RENDER,
    ST_WAIT_SWAP
  } wr_state_e;

  localparam fb_addr_t CLR_LAST = fb_addr_t'(FB_PIXELS - 1);

  function automatic fb_addr_t lin_addr(input logic [PX_X_W-1:0] x,
                                        input logic [PX_Y_W-1:0] y);
    fb_addr_t yy;
    yy = fb_addr_t'(y);
    return (yy << 8) + (yy << 6) + fb_addr_t'(x);
  endfunction

endpackage

// File: rtl/framebuffer_swap_ctrl_if.sv
// Renderer, VGA and memory signals of the framebuffer controller.
interface framebuffer_swap_ctrl_if #(
  parameter int unsigned COLOR_W = 8
);
  import framebuffer_swap_ctrl_pkg::*;

  logic [PX_X_W-1:0]  px_x;
  logic [PX_Y_W-1:0]  px_y;
  logic [COLOR_W-1:0] px_color;
  logic               px_we;
  logic               render_done;
  logic               render_ack;
  logic [COLOR_W-1:0] sky_color;
  logic [DRAW_W-1:0]  vga_drawX;
  logic [DRAW_W-1:0]  vga_drawY;
  logic               vga_vblank_start;
  logic [COLOR_W-1:0] vga_color;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [COLOR_W-1:0] mem_wdata;
  logic [ADDR_W-1:0]  mem_raddr;
  logic [COLOR_W-1:0] mem_rdata;
  logic               front_bank;
  logic               drop_err;

  // master: renderer / VGA timing / memory environment
  modport master (
    output px_x, px_y, px_color, px_we, render_done, sky_color,
           vga_drawX, vga_drawY, vga_vblank_start, mem_rdata,
    input  render_ack, vga_color, mem_we, mem_waddr, mem_wdata,
           mem_raddr, front_bank, drop_err
  );

  // slave: the framebuffer controller itself
  modport slave (
    input  px_x, px_y, px_color, px_we, render_done, sky_color,
           vga_drawX, vga_drawY, vga_vblank_start, mem_rdata,
    output render_ack, vga_color, mem_we, mem_waddr, mem_wdata,
           mem_raddr, front_bank, drop_err
  );
endinterface

// File: rtl/framebuffer_swap_ctrl_addr_gen.sv
// Combinational linear address y*320+x for a framebuffer coordinate.
module fb_addr_gen
  import framebuffer_swap_ctrl_pkg::*;
(
  input  logic [PX_X_W-1:0] i_x,
  input  logic [PX_Y_W-1:0] i_y,
  output fb_addr_t          o_lin
);
  assign o_lin = lin_addr(i_x, i_y);
endmodule

// File: rtl/framebuffer_swap_ctrl.sv
// Double-buffered framebuffer: clears/writes the back bank, reads the front
// bank for VGA, swaps banks at vblank after the renderer finishes a frame.
module framebuffer_swap_ctrl
  import framebuffer_swap_ctrl_pkg::*;
#(
  parameter int unsigned COLOR_W = framebuffer_swap_ctrl_pkg::COLOR_W,
  parameter int unsigned FB_W    = framebuffer_swap_ctrl_pkg::FB_W,
  parameter int unsigned FB_H    = framebuffer_swap_ctrl_pkg::FB_H,
  parameter int unsigned VIS_W   = framebuffer_swap_ctrl_pkg::VIS_W,
  parameter int unsigned VIS_H   = framebuffer_swap_ctrl_pkg::VIS_H
) (
  input logic                    clk,
  input logic                    rst_n,
  framebuffer_swap_ctrl_if.slave bus
);

  localparam logic [PX_X_W-1:0] X_LIM  = PX_X_W'(FB_W);
  localparam logic [PX_Y_W-1:0] Y_LIM  = PX_Y_W'(FB_H);
  localparam logic [DRAW_W-1:0] VX_LIM = DRAW_W'(VIS_W);
  localparam logic [DRAW_W-1:0] VY_LIM = DRAW_W'(VIS_H);

  wr_state_e          r_state, w_state_nxt;
  fb_addr_t           r_clr_ctr, w_clr_nxt;
  logic               r_front_bank, w_front_nxt;
  logic               r_done_seen, w_done_nxt;
  logic               r_drop_err, w_drop_nxt;
  logic               r_mem_we, w_we_nxt;
  logic [ADDR_W-1:0]  r_mem_waddr, w_waddr_nxt;
  logic [COLOR_W-1:0] r_mem_wdata, w_wdata_nxt;
  logic               r_ack, w_ack_nxt;
  logic               r_vis;
  logic [COLOR_W-1:0] r_vga_color;

  fb_addr_t w_wr_lin;
  fb_addr_t w_rd_lin;
  logic     w_px_ok;
  logic     w_vis;

  fb_addr_gen u_wr_addr (
    .i_x   (bus.px_x),
    .i_y   (bus.px_y),
    .o_lin (w_wr_lin)
  );

  // Each framebuffer pixel covers 2x2 VGA pixels.
  fb_addr_gen u_rd_addr (
    .i_x   (bus.vga_drawX[DRAW_W-1:1]),
    .i_y   (bus.vga_drawY[PX_Y_W:1]),
    .o_lin (w_rd_lin)
  );

  assign w_px_ok = (bus.px_x < X_LIM) && (bus.px_y < Y_LIM);
  assign w_vis   = (bus.vga_drawX < VX_LIM) && (bus.vga_drawY < VY_LIM);

  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = r_clr_ctr;
    w_front_nxt = r_front_bank;
    w_done_nxt  = r_done_seen;
    w_drop_nxt  = r_drop_err;
    w_we_nxt    = 1'b0;
    w_waddr_nxt = r_mem_waddr;
    w_wdata_nxt = r_mem_wdata;
    w_ack_nxt   = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_we_nxt    = 1'b1;
        w_waddr_nxt = {~r_front_bank, r_clr_ctr};
        w_wdata_nxt = bus.sky_color;
        if (bus.px_we) w_drop_nxt = 1'b1;
        if (r_clr_ctr == CLR_LAST) begin
          w_clr_nxt   = '0;
          w_state_nxt = ST_ACK;
        end else begin
          w_clr_nxt = r_clr_ctr + 1'b1;
        end
      end
      ST_ACK: begin
        w_ack_nxt   = 1'b1;
        w_state_nxt = ST_RENDER;
        if (bus.px_we) w_drop_nxt = 1'b1;
      end
      ST_RENDER: begin
        if (bus.px_we) begin
          if (w_px_ok) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = {~r_front_bank, w_wr_lin};
            w_wdata_nxt = bus.px_color;
          end else begin
            w_drop_nxt = 1'b1;
          end
        end
        // A coincident vblank is ignored here: the swap waits for the next one.
        if (bus.render_done) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_WAIT_SWAP;
        end
      end
      ST_WAIT_SWAP: begin
        if (bus.px_we) w_drop_nxt = 1'b1;
        if (bus.vga_vblank_start && r_done_seen) begin
          w_front_nxt = ~r_front_bank;
          w_done_nxt  = 1'b0;
          w_state_nxt = ST_CLEAR;
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_CLEAR;
      r_clr_ctr    <= '0;
      r_front_bank <= 1'b0;
      r_done_seen  <= 1'b0;
      r_drop_err   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_waddr  <= '0;
      r_mem_wdata  <= '0;
      r_ack        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clr_ctr    <= w_clr_nxt;
      r_front_bank <= w_front_nxt;
      r_done_seen  <= w_done_nxt;
      r_drop_err   <= w_drop_nxt;
      r_mem_we     <= w_we_nxt;
      r_mem_waddr  <= w_waddr_nxt;
      r_mem_wdata  <= w_wdata_nxt;
      r_ack        <= w_ack_nxt;
    end
  end

  // Read pipeline: address in cycle 0, memory data in cycle 1, colour in cycle 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vis       <= 1'b0;
      r_vga_color <= '0;
    end else begin
      r_vis       <= w_vis;
      r_vga_color <= r_vis ? bus.mem_rdata : '0;
    end
  end

  assign bus.mem_raddr  = {r_front_bank, w_vis ? w_rd_lin : fb_addr_t'(0)};
  assign bus.vga_color  = r_vga_color;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_waddr  = r_mem_waddr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.render_ack = r_ack;
  assign bus.front_bank = r_front_bank;
  assign bus.drop_err   = r_drop_err;

endmodule

// File: tb/tb_framebuffer_swap_ctrl.sv
// Directed bench for framebuffer_swap_ctrl with a read-path scoreboard.
module tb_framebuffer_swap_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  logic [7:0] exp_q[$];

  framebuffer_swap_ctrl_if #(.COLOR_W(8)) bus ();

  framebuffer_swap_ctrl #(.COLOR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_model(input logic [17:0] a);
    return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]};
  endfunction

  // One-cycle-latency read memory
  always @(posedge clk) bus.mem_rdata <= mem_model(bus.mem_raddr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic px_write(input int x, input int y, input logic [7:0] c);
    bus.px_x     = 9'(x);
    bus.px_y     = 8'(y);
    bus.px_color = c;
    bus.px_we    = 1'b1;
    step();
    bus.px_we    = 1'b0;
  endtask

  // Drives a stream of VGA coordinates; colours are popped two cycles later.
  task automatic vga_stream(input int xs[6], input int ys[6], input logic bank);
    logic [17:0] a;
    logic [7:0]  e;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        bus.vga_drawX = 10'(xs[i]);
        bus.vga_drawY = 10'(ys[i]);
        if (xs[i] < 640 && ys[i] < 480) begin
          a = {bank, 17'((ys[i] / 2) * 320 + (xs[i] / 2))};
          #1;
          chk($sformatf("raddr[%0d]", i), 32'(bus.mem_raddr), 32'(a));
          exp_q.push_back(mem_model(a));
        end else begin
          exp_q.push_back(8'h00);
        end
      end
      step();
      if (i >= 1 && i <= 6) begin
        e = exp_q.pop_front();
        chk($sformatf("vga_color[%0d]", i - 1), 32'(bus.vga_color), 32'(e));
      end
    end
  endtask

  initial begin
    int bad;
    int first_bad;
    int vx[6];
    int vy[6];
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.px_x = '0; bus.px_y = '0; bus.px_color = '0; bus.px_we = 1'b0;
    bus.render_done = 1'b0; bus.sky_color = 8'h2A;
    bus.vga_drawX = 10'd700; bus.vga_drawY = '0; bus.vga_vblank_start = 1'b0;
    repeat (3) step();

    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_ack", 32'(bus.render_ack), 32'd0);
    chk("rst_vga_color", 32'(bus.vga_color), 32'd0);
    chk("rst_drop_err", 32'(bus.drop_err), 32'd0);
    chk("rst_front_bank", 32'(bus.front_bank), 32'd0);

    rst_n = 1'b1;
    step();
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < 76800; i++) begin
      if (!(bus.mem_we === 1'b1 && bus.mem_waddr === {1'b1, 17'(i)} &&
            bus.mem_wdata === 8'h2A && bus.render_ack === 1'b0)) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      step();
    end
    chk("clear_bad_cycles", 32'(bad), 32'd0);
    chk("clear_first_bad", 32'(first_bad), 32'hFFFF_FFFF);
    chk("clear_end_we", 32'(bus.mem_we), 32'd0);
    chk("ack_high", 32'(bus.render_ack), 32'd1);
    step();
    chk("ack_one_cycle", 32'(bus.render_ack), 32'd0);

    px_write(319, 239, 8'h55);
    chk("wr_last_we", 32'(bus.mem_we), 32'd1);
    chk("wr_last_addr", 32'(bus.mem_waddr), 32'({1'b1, 17'd76799}));
    chk("wr_last_data", 32'(bus.mem_wdata), 32'h55);
    px_write(0, 1, 8'h77);
    chk("wr_row1_addr", 32'(bus.mem_waddr), 32'({1'b1, 17'd320}));
    chk("wr_row1_data", 32'(bus.mem_wdata), 32'h77);
    step();
    chk("wr_idle_we", 32'(bus.mem_we), 32'd0);
    chk("no_drop_yet", 32'(bus.drop_err), 32'd0);
    px_write(320, 10, 8'h11);
    chk("drop_x_we", 32'(bus.mem_we), 32'd0);
    chk("drop_x_err", 32'(bus.drop_err), 32'd1);
    px_write(0, 240, 8'h11);
    chk("drop_y_we", 32'(bus.mem_we), 32'd0);
    repeat (5) step();
    chk("drop_sticky", 32'(bus.drop_err), 32'd1);

    vx = '{5, 700, 639, 639, 0, 100};
    vy = '{3, 3, 479, 480, 0, 50};
    vga_stream(vx, vy, 1'b0);

    // render_done, a final write and vblank all in the same cycle
    bus.render_done = 1'b1;
    bus.vga_vblank_start = 1'b1;
    px_write(7, 2, 8'h99);
    bus.render_done = 1'b0;
    bus.vga_vblank_start = 1'b0;
    chk("done_write_we", 32'(bus.mem_we), 32'd1);
    chk("done_write_addr", 32'(bus.mem_waddr), 32'({1'b1, 17'd647}));
    chk("coincide_no_swap", 32'(bus.front_bank), 32'd0);
    px_write(1, 1, 8'h33);
    chk("wait_drop_we", 32'(bus.mem_we), 32'd0);
    repeat (100) step();
    chk("wait_still_bank0", 32'(bus.front_bank), 32'd0);
    bus.vga_vblank_start = 1'b1;
    step();
    bus.vga_vblank_start = 1'b0;
    chk("swap_bank1", 32'(bus.front_bank), 32'd1);
    step();
    chk("clr2_we", 32'(bus.mem_we), 32'd1);
    chk("clr2_addr0", 32'(bus.mem_waddr), 32'({1'b0, 17'd0}));
    chk("clr2_data", 32'(bus.mem_wdata), 32'h2A);
    step();
    chk("clr2_addr1", 32'(bus.mem_waddr), 32'({1'b0, 17'd1}));

    bus.vga_drawX = 10'd5;
    bus.vga_drawY = 10'd3;
    #1;
    chk("raddr_bank1", 32'(bus.mem_raddr), 32'({1'b1, 17'd322}));
    repeat (2) step();
    chk("vga_bank1", 32'(bus.vga_color), 32'(mem_model({1'b1, 17'd322})));

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("arst_ack", 32'(bus.render_ack), 32'd0);
    chk("arst_vga_color", 32'(bus.vga_color), 32'd0);
    chk("arst_front_bank", 32'(bus.front_bank), 32'd0);
    chk("arst_drop_err", 32'(bus.drop_err), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("reclr_we", 32'(bus.mem_we), 32'd1);
    chk("reclr_addr0", 32'(bus.mem_waddr), 32'({1'b1, 17'd0}));
    step();
    chk("reclr_addr1", 32'(bus.mem_waddr), 32'({1'b1, 17'd1}));
    chk("reclr_front", 32'(bus.front_bank), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
